// File: rtl/rv32i_lsu_ctrl.sv
// Purpose : RV32I load/store controller; decodes bank, checks legality/alignment, drives one bank access.
// Latency : legal request -> bank access 1 cycle after accept, resp_valid 2 cycles after; error -> resp 1 cycle after.
// Backpr. : one request in flight; o_req_ready only in IDLE, requester holds i_req_valid until accepted.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_req_*                  CPU request (valid, we, byte addr, funct3, store data)
//   o_req_ready              request acceptance (IDLE and out of reset)
//   o_resp_valid/o_resp_err  one-cycle completion pulse, err qualifies illegal requests
//   o_sel_addr/o_sel_funct3  request address/funct3 held for the load select/sign-extend stage
//   o_ir_cs/o_dr4k_cs/o_dr2k_cs, o_mem_we, o_mem_be, o_mem_waddr, o_mem_wdata
//                            registered bank-side access signals, active for one cycle
module rv32i_lsu_ctrl #(
    parameter int ADDR_W        = 13,
    parameter int IRAM_WRITABLE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [31:0]       i_req_addr,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_wdata,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic              o_resp_err,
    output logic [31:0]       o_sel_addr,
    output logic [2:0]        o_sel_funct3,
    output logic              o_ir_cs,
    output logic              o_dr4k_cs,
    output logic              o_dr2k_cs,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [31:0]       o_mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_sel_addr;
    logic [2:0]        r_sel_funct3;
    logic              r_ir_cs;
    logic              r_dr4k_cs;
    logic              r_dr2k_cs;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [31:0]       r_mem_wdata;

    // Next-state values produced by the combinational process
    state_t            w_nxt_state;
    logic              w_nxt_resp_valid;
    logic              w_nxt_resp_err;
    logic [31:0]       w_nxt_sel_addr;
    logic [2:0]        w_nxt_sel_funct3;
    logic              w_nxt_ir_cs;
    logic              w_nxt_dr4k_cs;
    logic              w_nxt_dr2k_cs;
    logic              w_nxt_mem_we;
    logic [3:0]        w_nxt_mem_be;
    logic [ADDR_W-1:0] w_nxt_mem_waddr;
    logic [31:0]       w_nxt_mem_wdata;

    // ------------------------------------------------------------------
    // Request decode (pure function of the request inputs)
    // ------------------------------------------------------------------
    logic              w_hit_iram;
    logic              w_hit_dr4k;
    logic              w_hit_dr2k;
    logic              w_unmapped;
    logic              w_funct3_ok;
    logic              w_misaligned;
    logic              w_iram_wr_err;
    logic              w_req_err;
    logic              w_accept;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_waddr;

    assign w_hit_iram = (i_req_addr[31:15] == 17'h00000);
    assign w_hit_dr4k = (i_req_addr[31:14] == 18'h00002);
    assign w_hit_dr2k = (i_req_addr[31:13] == 19'h00006);
    assign w_unmapped = ~(w_hit_iram | w_hit_dr4k | w_hit_dr2k);

    // Stores only have byte/half/word; loads add the unsigned byte/half forms.
    always_comb begin
        w_funct3_ok = 1'b0;
        if (i_req_we) begin
            case (i_req_funct3)
                3'b000, 3'b001, 3'b010: w_funct3_ok = 1'b1;
                default:                w_funct3_ok = 1'b0;
            endcase
        end else begin
            case (i_req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_funct3_ok = 1'b1;
                default:                                w_funct3_ok = 1'b0;
            endcase
        end
    end

    // funct3[1:0] encodes access size for every legal funct3
    assign w_misaligned = ((i_req_funct3[1:0] == 2'b01) &  i_req_addr[0]) |
                          ((i_req_funct3[1:0] == 2'b10) & (i_req_addr[1:0] != 2'b00));

    assign w_iram_wr_err = i_req_we & w_hit_iram & (IRAM_WRITABLE == 0);

    assign w_req_err = w_unmapped | ~w_funct3_ok | w_misaligned | w_iram_wr_err;

    assign w_accept  = i_req_valid & (r_state == S_IDLE);

    // Byte enables and lane-replicated data; the RAM picks lanes by mem_be.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_req_wdata;
        case (i_req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_req_addr[1:0];
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_req_wdata;
            end
        endcase
    end

    // Bank-local word index, zero-extended to the widest bank's index width
    always_comb begin
        w_waddr = '0;
        if (w_hit_iram) begin
            w_waddr = ADDR_W'(i_req_addr[14:2]);
        end else if (w_hit_dr4k) begin
            w_waddr = ADDR_W'(i_req_addr[13:2]);
        end else if (w_hit_dr2k) begin
            w_waddr = ADDR_W'(i_req_addr[12:2]);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_resp_valid = 1'b0;
        w_nxt_resp_err   = 1'b0;
        w_nxt_sel_addr   = r_sel_addr;
        w_nxt_sel_funct3 = r_sel_funct3;
        w_nxt_ir_cs      = 1'b0;
        w_nxt_dr4k_cs    = 1'b0;
        w_nxt_dr2k_cs    = 1'b0;
        w_nxt_mem_we     = 1'b0;
        w_nxt_mem_be     = 4'b0000;
        w_nxt_mem_waddr  = '0;
        w_nxt_mem_wdata  = 32'h0000_0000;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nxt_sel_addr   = i_req_addr;
                    w_nxt_sel_funct3 = i_req_funct3;
                    if (w_req_err) begin
                        // Illegal requests skip the bank cycle entirely
                        w_nxt_state      = S_RESP;
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_resp_err   = 1'b1;
                    end else begin
                        w_nxt_state     = S_ACCESS;
                        w_nxt_ir_cs     = w_hit_iram;
                        w_nxt_dr4k_cs   = w_hit_dr4k;
                        w_nxt_dr2k_cs   = w_hit_dr2k;
                        w_nxt_mem_waddr = w_waddr;
                        if (i_req_we) begin
                            w_nxt_mem_we    = 1'b1;
                            w_nxt_mem_be    = w_be;
                            w_nxt_mem_wdata = w_wdata;
                        end
                    end
                end
            end
            S_ACCESS: begin
                // Synchronous RAM read data lands during the RESP cycle
                w_nxt_state      = S_RESP;
                w_nxt_resp_valid = 1'b1;
            end
            S_RESP: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_sel_addr   <= 32'h0000_0000;
            r_sel_funct3 <= 3'b000;
            r_ir_cs      <= 1'b0;
            r_dr4k_cs    <= 1'b0;
            r_dr2k_cs    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= 32'h0000_0000;
        end else begin
            r_state      <= w_nxt_state;
            r_resp_valid <= w_nxt_resp_valid;
            r_resp_err   <= w_nxt_resp_err;
            r_sel_addr   <= w_nxt_sel_addr;
            r_sel_funct3 <= w_nxt_sel_funct3;
            r_ir_cs      <= w_nxt_ir_cs;
            r_dr4k_cs    <= w_nxt_dr4k_cs;
            r_dr2k_cs    <= w_nxt_dr2k_cs;
            r_mem_we     <= w_nxt_mem_we;
            r_mem_be     <= w_nxt_mem_be;
            r_mem_waddr  <= w_nxt_mem_waddr;
            r_mem_wdata  <= w_nxt_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Ready is forced low while reset is asserted so nothing is accepted then
    assign o_req_ready  = i_rst_n & (r_state == S_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_sel_addr   = r_sel_addr;
    assign o_sel_funct3 = r_sel_funct3;
    assign o_ir_cs      = r_ir_cs;
    assign o_dr4k_cs    = r_dr4k_cs;
    assign o_dr2k_cs    = r_dr2k_cs;
    assign o_mem_we     = r_mem_we;
    assign o_mem_be     = r_mem_be;
    assign o_mem_waddr  = r_mem_waddr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: doc/rv32i_lsu_ctrl.md
Name: rv32i_lsu_ctrl

Overview:
- Load/store access controller between the CPU data port and the three memory banks: IRAM (read-only), DRAM4K and DRAM2K.
- For each accepted request it decodes the target bank, checks legality and alignment, and drives one cycle of bank chip-select, word address, byte enables and lane-replicated write data.
- Holds the request address and funct3 stable for the downstream load-data select/sign-extend stage while synchronous-RAM read data returns, then signals completion.

Parameters:
- ADDR_W, 13, width of mem_waddr (bank-local word index, sized for the largest bank).
- IRAM_WRITABLE, 0: 0 makes IRAM stores an error; 1 allows them (used for boot loading).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  RV32I load/store funct3.
- req_wdata  in  32  store data (rs2).
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: request was illegal.
- sel_addr  out  32  registered address for the load select stage.
- sel_funct3  out  3  registered funct3 for the load select stage.
- ir_cs  out  1  IRAM chip select.
- dr4k_cs  out  1  DRAM4K chip select.
- dr2k_cs  out  1  DRAM2K chip select.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables; bit i = byte lane [8i+7:8i].
- mem_waddr  out  ADDR_W  bank-local word index.
- mem_wdata  out  32  lane-replicated store data.

Behaviour:

Reset:
- Sampled on rising clk while rst_n=0; state is IDLE.
- All outputs are 0, including req_ready, which is gated low during reset.

States: IDLE, ACCESS, RESP.
- req_ready=1 only in IDLE when rst_n=1.
- A request is accepted on a rising edge with req_valid & req_ready; it is captured into sel_addr, sel_funct3, the store data and the decode results.
- sel_addr and sel_funct3 hold until the next acceptance.

Bank decode:
- IRAM: addr[31:15]=0.
- DRAM4K: addr[31:14]=18'h00002.
- DRAM2K: addr[31:13]=19'h00006.
- Anything else is unmapped.

Error conditions (any one):
- Unmapped address.
- Load funct3 not in {000,001,010,100,101}.
- Store funct3 not in {000,001,010}.
- Halfword access with addr[0]=1.
- Word access with addr[1:0]≠0.
- Store to IRAM when IRAM_WRITABLE=0.

Legal request, accepted at edge T:
- Cycle T+1, ACCESS: exactly one cs high for one cycle. mem_waddr is bank-local (IRAM addr[14:2], DRAM4K addr[13:2], DRAM2K addr[12:2]), zero-extended to ADDR_W.
- Store in ACCESS: mem_we=1.
  - SB: mem_be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 4'b1100 : 4'b0011, mem_wdata={2{wdata[15:0]}}.
  - SW: mem_be=4'b1111, mem_wdata=wdata.
- Load in ACCESS: mem_we=0, mem_be=0.
- Cycle T+2, RESP: resp_valid=1, resp_err=0; all cs, mem_we and mem_be are 0. Load data from the select stage is valid in this cycle.
- Cycle T+3: IDLE. The earliest next acceptance is the T+3 edge.

Error request, accepted at edge T:
- Cycle T+1, RESP: resp_valid=1, resp_err=1.
- No cs, mem_we or mem_be is ever asserted.
- IDLE at T+2.

Output timing and boundary cases:
- All memory-side outputs are registered; no combinational path from req_* to cs, we or be.
- req_valid while not ready is ignored; the requester holds it.
- rst_n low in ACCESS or RESP: at that edge all outputs clear and no resp_valid follows. A store write in progress completes only if ACCESS was already driven before the reset edge.
- Highest in-bank addresses are legal: 0x00007FFC (LW), 0x0000BFFF (LB), 0x0000DFFE (LH).
- 0x0000E000 is unmapped.
- resp_valid is never asserted in consecutive cycles.

Test Plan:
- Reset, then SW addr 0x00008004, data 0xDEADBEEF, accepted at T → T+1: dr4k_cs=1, mem_we=1, mem_be=1111, mem_waddr=1, mem_wdata=0xDEADBEEF; T+2: resp_valid=1, resp_err=0; req_ready=1 at T+3.
- SB addr 0x0000C003, data 0x000000A5 → T+1: dr2k_cs=1, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_waddr=0; SH addr 0x0000C002, data 0x1234 → mem_be=1100, mem_wdata=0x12341234.
- LH addr 0x00000006 → T+1: ir_cs=1, mem_we=0, mem_waddr=1; sel_addr=0x00000006 and sel_funct3=001 held through T+2; resp_valid at T+2.
- Errors, each giving resp_valid=1 and resp_err=1 at T+1 with no cs ever high:
  - LW addr 0x00008002 (misaligned).
  - LB addr 0x0000E000 (unmapped).
  - SW addr 0x00000000 with IRAM_WRITABLE=0.
  - Load funct3=011 (illegal).
- Back-to-back: req_valid held high with two SWs → second accepted at T+3, exactly one resp per request; rst_n=0 during ACCESS of an LW → outputs 0 next cycle, no resp_valid, req_ready=1 one cycle after rst_n returns to 1.
